// File: rtl/bp_mmio_mc_mailbox.sv
// Memory-mapped mailbox between a BlackParrot I/O port and a manycore endpoint.
// Optional perf counters at 0x07000/0x07008/0x07010 when BP_MMIO_MC_MAILBOX_PERF_EN is defined.

module bp_mmio_mc_mailbox_fifo #(
  parameter int width_p = 128,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enq_i,
  input  logic [width_p-1:0] data_i,
  input  logic               deq_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [width_p-1:0] head_o
);
  localparam int aw_lp = $clog2(els_p);

  logic [width_p-1:0] mem [els_p];
  logic [aw_lp:0]     wptr_reg, rptr_reg;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else begin
      if (enq_i) wptr_reg <= wptr_reg + (aw_lp+1)'(1);
      if (deq_i) rptr_reg <= rptr_reg + (aw_lp+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_i) mem[wptr_reg[aw_lp-1:0]] <= data_i;
  end

  assign empty_o = (wptr_reg == rptr_reg);
  assign full_o  = (wptr_reg[aw_lp] != rptr_reg[aw_lp])
                && (wptr_reg[aw_lp-1:0] == rptr_reg[aw_lp-1:0]);
  assign head_o  = mem[rptr_reg[aw_lp-1:0]];
endmodule

module bp_mmio_mc_mailbox #(
  parameter int word_width_p  = 64,
  parameter int pkt_width_p   = 128,
  parameter int fifo_els_p    = 4,
  parameter int max_credits_p = 15
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    io_cmd_v_i,
  output logic                    io_cmd_ready_and_o,
  input  logic                    io_cmd_wr_i,
  input  logic [19:0]             io_cmd_addr_i,
  input  logic [word_width_p-1:0] io_cmd_data_i,
  output logic                    io_resp_v_o,
  input  logic                    io_resp_yumi_i,
  output logic [word_width_p-1:0] io_resp_data_o,
  output logic                    io_resp_wr_o,
  output logic                    mc_out_v_o,
  output logic [pkt_width_p-1:0]  mc_out_pkt_o,
  input  logic                    mc_out_ready_i,
  input  logic                    mc_credit_return_i,
  input  logic                    mc_resp_v_i,
  input  logic [pkt_width_p-1:0]  mc_resp_pkt_i,
  output logic                    mc_resp_ready_o,
  input  logic                    mc_req_v_i,
  input  logic [pkt_width_p-1:0]  mc_req_pkt_i,
  output logic                    mc_req_ready_o
);
  localparam int pkt_words_lp  = pkt_width_p / word_width_p;
  localparam int cnt_width_lp  = $clog2(fifo_els_p*pkt_words_lp+1);
  localparam int cred_width_lp = $clog2(max_credits_p+1);
  localparam int idx_width_lp  = (pkt_words_lp > 1) ? $clog2(pkt_words_lp) : 1;

  localparam logic [19:0] addr_bp_req   = 20'h01000;
  localparam logic [19:0] addr_credits  = 20'h02000;
  localparam logic [19:0] addr_resp_pop = 20'h03000;
  localparam logic [19:0] addr_resp_cnt = 20'h04000;
  localparam logic [19:0] addr_req_pop  = 20'h05000;
  localparam logic [19:0] addr_req_cnt  = 20'h06000;

  typedef enum logic {IDLE, RESP} state_e;
  state_e state_reg, state_next;

  logic                     cmd_ready, cmd_accept;
  logic [word_width_p-1:0]  resp_data_reg, resp_data_next;
  logic                     resp_wr_reg;

  logic                     bp_full, bp_empty, bp_push, bp_enq, bp_deq;
  logic [pkt_width_p-1:0]   bp_head, acc_reg, acc_pkt;
  logic [idx_width_lp-1:0]  acc_idx_reg;
  logic                     acc_last;
  logic [cred_width_lp-1:0] outstanding_reg;
  logic                     credit_ret;

  logic [1:0]               in_v, in_ready, in_enq, in_pop;
  logic [pkt_width_p-1:0]   in_pkt  [2];
  logic [word_width_p-1:0]  in_word [2];
  logic [cnt_width_lp-1:0]  in_cnt  [2];

  // Outbound: words are assembled low-first; the last word completes the packet.
  assign acc_last = (acc_idx_reg == idx_width_lp'(pkt_words_lp-1));
  always_comb begin
    acc_pkt = acc_reg;
    acc_pkt[acc_idx_reg*word_width_p +: word_width_p] = io_cmd_data_i;
  end

  assign bp_push = cmd_accept && io_cmd_wr_i && (io_cmd_addr_i == addr_bp_req);
  assign bp_enq  = bp_push && acc_last;

  bp_mmio_mc_mailbox_fifo #(.width_p(pkt_width_p), .els_p(fifo_els_p)) bp_req_fifo (
    .clk_i(clk_i), .reset_i(reset_i), .enq_i(bp_enq), .data_i(acc_pkt),
    .deq_i(bp_deq), .full_o(bp_full), .empty_o(bp_empty), .head_o(bp_head)
  );

  assign mc_out_v_o   = !bp_empty && (outstanding_reg < cred_width_lp'(max_credits_p));
  assign mc_out_pkt_o = bp_empty ? '0 : bp_head;
  assign bp_deq       = mc_out_v_o && mc_out_ready_i;
  assign credit_ret   = mc_credit_return_i && (outstanding_reg != '0);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc_reg         <= '0;
      acc_idx_reg     <= '0;
      outstanding_reg <= '0;
    end else begin
      if (bp_push) begin
        acc_reg     <= acc_last ? '0 : acc_pkt;
        acc_idx_reg <= acc_last ? '0 : acc_idx_reg + idx_width_lp'(1);
      end
      case ({bp_deq, credit_ret})
        2'b10:   outstanding_reg <= outstanding_reg + cred_width_lp'(1);
        2'b01:   outstanding_reg <= outstanding_reg - cred_width_lp'(1);
        default: ;
      endcase
    end
  end

  credit_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(mc_credit_return_i && outstanding_reg == '0));

  // Inbound queues: index 0 is MC_RESP, index 1 is MC_REQ.
  assign in_v      = {mc_req_v_i, mc_resp_v_i};
  assign in_pkt[0] = mc_resp_pkt_i;
  assign in_pkt[1] = mc_req_pkt_i;
  assign mc_resp_ready_o = in_ready[0];
  assign mc_req_ready_o  = in_ready[1];

  for (genvar gi = 0; gi < 2; gi++) begin : g_in
    localparam logic [19:0] pop_addr = (gi == 0) ? addr_resp_pop : addr_req_pop;
    logic                    full, empty, deq;
    logic [pkt_width_p-1:0]  head;
    logic [idx_width_lp-1:0] off_reg;
    logic [cnt_width_lp-1:0] cnt_reg;

    assign in_ready[gi] = !full && !reset_i;
    assign in_enq[gi]   = in_v[gi] && in_ready[gi];
    assign in_pop[gi]   = cmd_accept && !io_cmd_wr_i && (io_cmd_addr_i == pop_addr);
    assign deq          = in_pop[gi] && (off_reg == idx_width_lp'(pkt_words_lp-1));
    assign in_word[gi]  = head[off_reg*word_width_p +: word_width_p];
    assign in_cnt[gi]   = cnt_reg;

    bp_mmio_mc_mailbox_fifo #(.width_p(pkt_width_p), .els_p(fifo_els_p)) fifo (
      .clk_i(clk_i), .reset_i(reset_i), .enq_i(in_enq[gi]), .data_i(in_pkt[gi]),
      .deq_i(deq), .full_o(full), .empty_o(empty), .head_o(head)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        off_reg <= '0;
        cnt_reg <= '0;
      end else begin
        if (in_pop[gi]) off_reg <= deq ? '0 : off_reg + idx_width_lp'(1);
        cnt_reg <= cnt_reg + (in_enq[gi] ? cnt_width_lp'(pkt_words_lp) : '0)
                           - (in_pop[gi] ? cnt_width_lp'(1) : '0);
      end
    end
  end

`ifdef BP_MMIO_MC_MAILBOX_PERF_EN
  localparam logic [19:0] addr_perf_sent  = 20'h07000;
  localparam logic [19:0] addr_perf_stall = 20'h07008;
  localparam logic [19:0] addr_perf_in    = 20'h07010;

  logic [31:0] perf_sent_reg, perf_stall_reg, perf_in_reg;
  logic        perf_wr;

  function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [1:0] inc);
    logic [32:0] s;
    s = {1'b0, v} + {31'b0, inc};
    return s[32] ? '1 : s[31:0];
  endfunction

  assign perf_wr = cmd_accept && io_cmd_wr_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      perf_sent_reg  <= '0;
      perf_stall_reg <= '0;
      perf_in_reg    <= '0;
    end else begin
      perf_sent_reg  <= (perf_wr && io_cmd_addr_i == addr_perf_sent) ? '0
                      : sat_add(perf_sent_reg, {1'b0, bp_deq});
      perf_stall_reg <= (perf_wr && io_cmd_addr_i == addr_perf_stall) ? '0
                      : sat_add(perf_stall_reg,
                          {1'b0, !bp_empty && outstanding_reg == cred_width_lp'(max_credits_p)});
      perf_in_reg    <= (perf_wr && io_cmd_addr_i == addr_perf_in) ? '0
                      : sat_add(perf_in_reg, {1'b0, in_enq[0]} + {1'b0, in_enq[1]});
    end
  end
`endif

  always_comb begin
    cmd_ready      = 1'b1;
    resp_data_next = '0;
    case (io_cmd_addr_i)
      addr_bp_req:   if (io_cmd_wr_i) cmd_ready = !(acc_last && bp_full);
      addr_credits:  if (!io_cmd_wr_i)
                       resp_data_next[cred_width_lp-1:0] = cred_width_lp'(max_credits_p) - outstanding_reg;
      addr_resp_pop: if (!io_cmd_wr_i) begin
                       cmd_ready      = (in_cnt[0] != '0);
                       resp_data_next = in_word[0];
                     end
      addr_resp_cnt: if (!io_cmd_wr_i) resp_data_next[cnt_width_lp-1:0] = in_cnt[0];
      addr_req_pop:  if (!io_cmd_wr_i) begin
                       cmd_ready      = (in_cnt[1] != '0);
                       resp_data_next = in_word[1];
                     end
      addr_req_cnt:  if (!io_cmd_wr_i) resp_data_next[cnt_width_lp-1:0] = in_cnt[1];
`ifdef BP_MMIO_MC_MAILBOX_PERF_EN
      addr_perf_sent:  if (!io_cmd_wr_i) resp_data_next[31:0] = perf_sent_reg;
      addr_perf_stall: if (!io_cmd_wr_i) resp_data_next[31:0] = perf_stall_reg;
      addr_perf_in:    if (!io_cmd_wr_i) resp_data_next[31:0] = perf_in_reg;
`endif
      default: ;
    endcase

    io_cmd_ready_and_o = (state_reg == IDLE) && cmd_ready && !reset_i;
    cmd_accept         = io_cmd_ready_and_o && io_cmd_v_i;

    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cmd_accept) state_next = RESP;
      RESP:    if (io_resp_yumi_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg     <= IDLE;
      resp_data_reg <= '0;
      resp_wr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (cmd_accept) begin
        resp_data_reg <= resp_data_next;
        resp_wr_reg   <= io_cmd_wr_i;
      end
    end
  end

  assign io_resp_v_o    = (state_reg == RESP);
  assign io_resp_data_o = resp_data_reg;
  assign io_resp_wr_o   = resp_wr_reg;
endmodule

// File: tb/tb_bp_mmio_mc_mailbox.sv
// Scoreboard bench for bp_mmio_mc_mailbox: stimulus pushes expectations,
// a forked monitor compares responses and outbound packets as they appear.
module tb_bp_mmio_mc_mailbox;
  localparam logic [19:0] A_BPREQ = 20'h01000, A_CRED = 20'h02000, A_RPOP = 20'h03000,
                          A_RCNT  = 20'h04000, A_QPOP = 20'h05000, A_QCNT = 20'h06000;

  logic         clk_i = 1'b0, reset_i = 1'b1;
  logic         io_cmd_v_i = 1'b0, io_cmd_wr_i = 1'b0;
  logic [19:0]  io_cmd_addr_i = '0;
  logic [63:0]  io_cmd_data_i = '0;
  logic         io_resp_yumi_i = 1'b1, mc_out_ready_i = 1'b1, mc_credit_return_i = 1'b0;
  logic         mc_resp_v_i = 1'b0, mc_req_v_i = 1'b0;
  logic [127:0] mc_resp_pkt_i = '0, mc_req_pkt_i = '0;
  logic         io_cmd_ready_and_o, io_resp_v_o, io_resp_wr_o, mc_out_v_o;
  logic         mc_resp_ready_o, mc_req_ready_o;
  logic [63:0]  io_resp_data_o;
  logic [127:0] mc_out_pkt_o;

  int tests = 0, fails = 0;
  logic [63:0]  resp_q[$];
  logic         resp_wr_q[$];
  logic [127:0] out_q[$];

  bp_mmio_mc_mailbox dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .io_cmd_v_i(io_cmd_v_i), .io_cmd_ready_and_o(io_cmd_ready_and_o), .io_cmd_wr_i(io_cmd_wr_i),
    .io_cmd_addr_i(io_cmd_addr_i), .io_cmd_data_i(io_cmd_data_i),
    .io_resp_v_o(io_resp_v_o), .io_resp_yumi_i(io_resp_yumi_i),
    .io_resp_data_o(io_resp_data_o), .io_resp_wr_o(io_resp_wr_o),
    .mc_out_v_o(mc_out_v_o), .mc_out_pkt_o(mc_out_pkt_o), .mc_out_ready_i(mc_out_ready_i),
    .mc_credit_return_i(mc_credit_return_i),
    .mc_resp_v_i(mc_resp_v_i), .mc_resp_pkt_i(mc_resp_pkt_i), .mc_resp_ready_o(mc_resp_ready_o),
    .mc_req_v_i(mc_req_v_i), .mc_req_pkt_i(mc_req_pkt_i), .mc_req_ready_o(mc_req_ready_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, wanted %h", name, act, exp);
    end else
      $display("[TB] ok %s = %h", name, act);
  endtask

  task automatic cmd(input logic wr, input logic [19:0] a, input logic [63:0] d,
                     input logic [63:0] exp);
    int n;
    n = 0;
    io_cmd_v_i = 1'b1; io_cmd_wr_i = wr; io_cmd_addr_i = a; io_cmd_data_i = d;
    resp_q.push_back(exp);
    resp_wr_q.push_back(wr);
    @(negedge clk_i);
    while (!io_cmd_ready_and_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL cmd_timeout: addr %h never accepted, wanted accept within 100 cycles", a);
      io_cmd_v_i = 1'b0;
      resp_q.delete(resp_q.size()-1);
      resp_wr_q.delete(resp_wr_q.size()-1);
      @(posedge clk_i); #1;
      return;
    end
    @(posedge clk_i); #1;
    io_cmd_v_i = 1'b0;
    check("resp_latency", io_resp_v_o, 1);
    @(posedge clk_i); #1;
  endtask

  task automatic inject(input int q, input logic [127:0] p);
    int n;
    n = 0;
    if (q == 0) begin mc_resp_v_i = 1'b1; mc_resp_pkt_i = p; end
    else        begin mc_req_v_i  = 1'b1; mc_req_pkt_i  = p; end
    @(negedge clk_i);
    while (!((q == 0) ? mc_resp_ready_o : mc_req_ready_o) && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL inject_timeout: queue %0d never ready, wanted ready within 100 cycles", q);
    end
    @(posedge clk_i); #1;
    mc_resp_v_i = 1'b0; mc_req_v_i = 1'b0;
  endtask

  task automatic credit(input int n);
    mc_credit_return_i = 1'b1;
    repeat (n) @(posedge clk_i);
    #1 mc_credit_return_i = 1'b0;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk_i);
        if (!reset_i) begin
          if (io_resp_v_o) begin
            if (resp_q.size() == 0) begin
              tests++; fails++;
              $display("FAIL resp_unexpected: got data %h, wanted no response", io_resp_data_o);
            end else begin
              check("resp_data", io_resp_data_o, resp_q.pop_front());
              check("resp_wr", io_resp_wr_o, resp_wr_q.pop_front());
            end
          end
          if (mc_out_v_o && mc_out_ready_i) begin
            if (out_q.size() == 0) begin
              tests++; fails++;
              $display("FAIL out_unexpected: got pkt %h, wanted no packet", mc_out_pkt_o);
            end else
              check("out_pkt", mc_out_pkt_o, out_q.pop_front());
          end
        end
      end
    join_none

    // reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_resp_v", io_resp_v_o, 0);
    check("rst_out_v", mc_out_v_o, 0);
    check("rst_out_pkt", mc_out_pkt_o, 0);
    check("rst_cmd_ready", io_cmd_ready_and_o, 0);
    check("rst_resp_ready", mc_resp_ready_o, 0);
    @(posedge clk_i); #1 reset_i = 1'b0;
    #1 check("req_ready_after_rst", mc_req_ready_o, 1);
    @(posedge clk_i); #1;

    // two words -> one packet, one credit used
    out_q.push_back({64'h22, 64'h11});
    cmd(1'b1, A_BPREQ, 64'h11, 64'h0);
    cmd(1'b1, A_BPREQ, 64'h22, 64'h0);
    cmd(1'b0, A_CRED, 64'h0, 64'd14);
    check("t1_sent", out_q.size(), 0);
    credit(1);

    // credit exhaustion: 16 packets, 15 go out
    for (int i = 0; i < 16; i++) begin
      out_q.push_back({64'h100 + 64'(i), 64'h200 + 64'(i)});
      cmd(1'b1, A_BPREQ, 64'h200 + 64'(i), 64'h0);
      cmd(1'b1, A_BPREQ, 64'h100 + 64'(i), 64'h0);
    end
    @(negedge clk_i);
    check("held_out_v", mc_out_v_o, 0);
    check("held_pending", out_q.size(), 1);
    @(posedge clk_i); #1;
    cmd(1'b0, A_CRED, 64'h0, 64'd0);
    credit(1);
    @(negedge clk_i);
    check("out_v_after_credit", mc_out_v_o, 1);
    @(posedge clk_i); #1;
    check("held_drained", out_q.size(), 0);
    credit(15);
    cmd(1'b0, A_CRED, 64'h0, 64'd15);

    // MC_RESP word pops
    inject(0, {64'hAAAA, 64'hBBBB});
    cmd(1'b0, A_RCNT, 64'h0, 64'd2);
    cmd(1'b0, A_RPOP, 64'h0, 64'hBBBB);
    cmd(1'b0, A_RPOP, 64'h0, 64'hAAAA);
    cmd(1'b0, A_RCNT, 64'h0, 64'd0);

    // wrong-direction and unmapped accesses
    cmd(1'b0, A_BPREQ, 64'h0, 64'h0);
    cmd(1'b1, A_CRED, 64'h5, 64'h0);
    cmd(1'b0, 20'h0ABCD, 64'h0, 64'h0);
    cmd(1'b1, A_RCNT, 64'h9, 64'h0);

    // MC_REQ pop stalls until a packet arrives
    fork
      cmd(1'b0, A_QPOP, 64'h0, 64'hC1);
      begin
        repeat (3) begin
          @(negedge clk_i);
          check("req_pop_stall", io_cmd_ready_and_o, 0);
        end
        @(posedge clk_i); #1;
        inject(1, {64'hC2, 64'hC1});
      end
    join
    cmd(1'b0, A_QPOP, 64'h0, 64'hC2);
    cmd(1'b0, A_QCNT, 64'h0, 64'd0);

    // fill MC_REQ, then enqueue at the slot freed by a retiring head
    for (int i = 0; i < 4; i++) inject(1, {64'h300 + 64'(i), 64'h400 + 64'(i)});
    @(negedge clk_i);
    check("req_full_ready", mc_req_ready_o, 0);
    @(posedge clk_i); #1;
    cmd(1'b0, A_QCNT, 64'h0, 64'd8);
    cmd(1'b0, A_QPOP, 64'h0, 64'h400);
    cmd(1'b0, A_QPOP, 64'h0, 64'h300);
    cmd(1'b0, A_QPOP, 64'h0, 64'h401);
    fork
      cmd(1'b0, A_QPOP, 64'h0, 64'h301);
      inject(1, {64'h304, 64'h404});
    join
    cmd(1'b0, A_QCNT, 64'h0, 64'd6);
    for (int i = 2; i < 5; i++) begin
      cmd(1'b0, A_QPOP, 64'h0, 64'h400 + 64'(i));
      cmd(1'b0, A_QPOP, 64'h0, 64'h300 + 64'(i));
    end
    cmd(1'b0, A_QCNT, 64'h0, 64'd0);

    // reset with a half-built packet
    cmd(1'b1, A_BPREQ, 64'h33, 64'h0);
    reset_i = 1'b1;
    @(negedge clk_i);
    check("midrst_resp_v", io_resp_v_o, 0);
    check("midrst_cmd_ready", io_cmd_ready_and_o, 0);
    check("midrst_out_v", mc_out_v_o, 0);
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
    out_q.push_back({64'h55, 64'h44});
    cmd(1'b1, A_BPREQ, 64'h44, 64'h0);
    cmd(1'b1, A_BPREQ, 64'h55, 64'h0);
    repeat (2) @(posedge clk_i);
    #1;
    check("final_out_drained", out_q.size(), 0);
    check("final_resp_drained", resp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bp_mmio_mc_mailbox.md
Name: bp_mmio_mc_mailbox

Overview:
- Parametrised memory-mapped mailbox between a BlackParrot I/O command/response port and a manycore endpoint-side packet interface.
- Three queues: BP-to-MC requests (packed from words), MC-to-BP responses and MC-to-BP requests (unpacked into words).
- Adds credit-gated outbound flow, a readable MC request queue, and word-accurate entry counts.
- Sits between the BP I/O crossbar and a bsg_manycore_endpoint_standard wrapper.

Parameters:
- word_width_p, 64, I/O data word width.
- pkt_width_p, 128, host packet width; must be an integer multiple of word_width_p; pkt_words_lp = pkt_width_p/word_width_p.
- fifo_els_p, 4, depth in packets of each of the three queues; power of two, minimum 2.
- max_credits_p, 15, maximum outstanding outbound requests.
- cnt_width_lp, derived, $clog2(fifo_els_p*pkt_words_lp+1).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- io_cmd_v_i  in  1  command valid
- io_cmd_ready_and_o  out  1  command accept
- io_cmd_wr_i  in  1  1=write, 0=read
- io_cmd_addr_i  in  20  device-local address
- io_cmd_data_i  in  word_width_p  write data
- io_resp_v_o  out  1  response valid
- io_resp_yumi_i  in  1  response consumed
- io_resp_data_o  out  word_width_p  read data; 0 for writes
- io_resp_wr_o  out  1  echoes the command's io_cmd_wr_i
- mc_out_v_o  out  1  outbound packet valid
- mc_out_pkt_o  out  pkt_width_p  outbound packet
- mc_out_ready_i  in  1  endpoint can take the packet
- mc_credit_return_i  in  1  one credit returned
- mc_resp_v_i / mc_resp_pkt_i / mc_resp_ready_o  in/in/out  1/pkt_width_p/1  inbound response packet
- mc_req_v_i / mc_req_pkt_i / mc_req_ready_o  in/in/out  1/pkt_width_p/1  inbound request packet

Behaviour:
- Reset: all outputs 0; every queue empty; partial-packet accumulator cleared; outstanding count 0; FSM in IDLE. A reset mid-packet or mid-response drops the partial state.
- FSM states: IDLE and RESP.
  - IDLE: io_cmd_ready_and_o = 1 only when the addressed target can complete (see the address map below). On acceptance, register the response data and move to RESP.
  - RESP: io_resp_v_o = 1; return to IDLE on io_resp_yumi_i.
  - Only one command is in flight. Response latency is exactly 1 cycle after acceptance.
- Address map (io_cmd_addr_i[19:0]):
  - 0x01000 W: push a word into the BP_REQ accumulator. Stalls while the accumulator holds pkt_words_lp-1 words and BP_REQ is full. Words fill low word first; the packet enqueues on its pkt_words_lp-th word.
  - 0x02000 R: credits available = max_credits_p - outstanding.
  - 0x03000 R: pop one word from MC_RESP, low word first. Stalls (not ready) while MC_RESP is empty.
  - 0x04000 R: MC_RESP word count.
  - 0x05000 R: pop one word from MC_REQ; same rules as 0x03000.
  - 0x06000 R: MC_REQ word count.
  - A read of a write-only address, a write of a read-only address, or any unmapped address: accepted immediately, no side effect, response data 0.
- Outbound:
  - mc_out_v_o = BP_REQ not empty && outstanding < max_credits_p.
  - Dequeue when mc_out_v_o && mc_out_ready_i, and outstanding increments.
  - mc_credit_return_i decrements outstanding. A send and a return in the same cycle leave it unchanged.
  - A credit return with outstanding = 0 is ignored and triggers an assertion.
- Inbound:
  - mc_*_ready_o = queue not full; enqueue on v && ready.
  - Word count rises by pkt_words_lp on enqueue and falls by 1 on each word pop. Simultaneous enqueue and pop changes it by pkt_words_lp-1.
  - Enqueue into a queue at its last free slot is allowed the same cycle its head packet retires.
- Count width is cnt_width_lp; readouts are zero-extended to word_width_p.

Optional Feature:
- BP_MMIO_MC_MAILBOX_PERF_EN defined: adds 32-bit saturating counters, readable at these addresses (zero-extended), cleared by reset or by any write to the same address:
  - 0x07000: packets sent.
  - 0x07008: cycles stalled on credits (BP_REQ non-empty and outstanding = max_credits_p).
  - 0x07010: inbound packets accepted.
- Undefined: 0x07xxx behaves as unmapped; no counter logic is present.

Test Plan:
- Write 0x11, then 0x22, to 0x01000 (pkt_words_lp=2), mc_out_ready_i=1 -> one mc_out packet 0x22_0000000000000011 (upper/lower words); read 0x02000 returns 14.
- With mc_out_ready_i=1 and no credit returns, 16 packets enqueued over time -> 15 sent, 16th held with mc_out_v_o=0; one mc_credit_return_i pulse -> 16th sent on next cycle.
- Inject mc_resp_pkt_i=0xAAAA_BBBB (128b) -> 0x04000 reads 2, 0x03000 reads low then high word, 0x04000 then reads 0.
- Read 0x05000 with MC_REQ empty -> no cmd ready; inject a packet 3 cycles later -> response valid 1 cycle after acceptance with low word.
- Fill MC_REQ to fifo_els_p packets -> mc_req_ready_o=0; pop the final word of the head while a new packet arrives -> count unchanged net +pkt_words_lp-1, no loss.
- Assert reset_i after one word written to 0x01000 -> accumulator cleared; next two writes form a clean packet; io_resp_v_o=0 during reset.
